// File: rtl/swb_pkg.sv
// rtl/swb_pkg.sv - shared store write buffer types and sizing for the ISU and SWB
package swb_pkg;

   // Default SWB entry count; also the credit pool the ISU starts with
   localparam int SWB_DEPTH = 8;

   // Width of the SWB slot id carried with every issued store
   localparam int SWB_ID_W = $clog2(SWB_DEPTH);

   // One store request as held in the input queue and issued to the SWB
   typedef struct packed {
      logic [31:0]  addr;
      logic [127:0] data;
   } swb_req_t;

endpackage

// File: rtl/swb_isu_if.sv
// rtl/swb_isu_if.sv - upstream request, downstream issue and credit-return signals of the ISU
interface swb_isu_if #(
   parameter int SWB_DEPTH = swb_pkg::SWB_DEPTH
);

   localparam int ID_W = $clog2(SWB_DEPTH);

   // Upstream store request channel
   logic            u_req_valid;
   logic            u_req_ready;
   logic [31:0]     u_req_addr;
   logic [127:0]    u_req_data;

   // Downstream issue channel towards the SWB
   logic            d_req_valid;
   logic            d_req_ready;
   logic [ID_W-1:0] d_req_id;
   logic [31:0]     d_req_addr;
   logic [127:0]    d_req_data;

   // One pulse per freed SWB slot
   logic            d_isu_crdt_rtn;

   // Requester / SWB side
   modport master (
      output u_req_valid, u_req_addr, u_req_data, d_req_ready, d_isu_crdt_rtn,
      input  u_req_ready, d_req_valid, d_req_id, d_req_addr, d_req_data
   );

   // ISU side
   modport slave (
      input  u_req_valid, u_req_addr, u_req_data, d_req_ready, d_isu_crdt_rtn,
      output u_req_ready, d_req_valid, d_req_id, d_req_addr, d_req_data
   );

endinterface

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with extra-MSB pointers and unregistered head output
module sync_fifo #(
   parameter int WIDTH = 160,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = 1;

   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic [WIDTH-1:0] mem [DEPTH];
   logic             do_push;
   logic             do_pop;

   // Guard against over/underflow here so callers cannot corrupt the pointers
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   // Pointers carry one extra wrap bit so full and empty are distinguishable
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
   assign dout  = mem[rd_ptr[AW-1:0]];

   // Pointer advance; reset empties the queue without touching storage
   always_ff @(posedge clk) begin
      if (!rstn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
         if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

   // Payload storage is left unreset; only the pointers define validity
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/swb_isu.sv
// rtl/swb_isu.sv - store issue unit: queues stores and issues them to the SWB under credit control
module swb_isu #(
   parameter int SWB_DEPTH = swb_pkg::SWB_DEPTH,
   parameter int IQ_DEPTH  = 4
) (
   input  logic                             clk,
   input  logic                             rstn,
   swb_isu_if.slave                         bus,
   output logic [$clog2(SWB_DEPTH+1)-1:0]   crdt_cnt,
   output logic                             idle,
   output logic                             err_crdt_ovf
);

   import swb_pkg::*;

   localparam int              ID_W     = $clog2(SWB_DEPTH);
   localparam int              CNT_W    = $clog2(SWB_DEPTH + 1);
   localparam logic [CNT_W-1:0] CRDT_MAX = CNT_W'(SWB_DEPTH);
   localparam logic [CNT_W-1:0] CNT_ONE  = 1;
   localparam logic [ID_W-1:0]  ID_MAX   = ID_W'(SWB_DEPTH - 1);
   localparam logic [ID_W-1:0]  ID_ONE   = 1;

   swb_req_t        wr_req;
   swb_req_t        head;
   logic            q_full;
   logic            q_empty;
   logic            issue;
   logic            rtn;
   logic [ID_W-1:0] id_cnt;

   // The queue never bypasses: a full queue refuses even when it pops this cycle
   assign bus.u_req_ready = !q_full;
   assign wr_req.addr     = bus.u_req_addr;
   assign wr_req.data     = bus.u_req_data;

   sync_fifo #(
      .WIDTH ($bits(swb_req_t)),
      .DEPTH (IQ_DEPTH)
   ) u_iq (
      .clk   (clk),
      .rstn  (rstn),
      .push  (bus.u_req_valid),
      .pop   (issue),
      .din   (wr_req),
      .dout  (head),
      .full  (q_full),
      .empty (q_empty)
   );

   // Valid comes only from registered state, so it cannot drop or glitch while stalled
   assign bus.d_req_valid = !q_empty && (crdt_cnt != '0);
   assign bus.d_req_addr  = head.addr;
   assign bus.d_req_data  = head.data;
   assign bus.d_req_id    = id_cnt;

   assign issue = bus.d_req_valid && bus.d_req_ready;
   assign rtn   = bus.d_isu_crdt_rtn;
   assign idle  = q_empty && (crdt_cnt == CRDT_MAX);

   // Slot id advances once per issued store and wraps at the SWB size
   always_ff @(posedge clk) begin
      if (!rstn) begin
         id_cnt <= '0;
      end else if (issue) begin
         id_cnt <= (id_cnt == ID_MAX) ? '0 : id_cnt + ID_ONE;
      end
   end

   // Credit pool: issue consumes, return refills, both together cancel; excess returns are flagged
   always_ff @(posedge clk) begin
      if (!rstn) begin
         crdt_cnt     <= CRDT_MAX;
         err_crdt_ovf <= 1'b0;
      end else begin
         unique case ({issue, rtn})
            2'b10: crdt_cnt <= crdt_cnt - CNT_ONE;
            2'b01: begin
               if (crdt_cnt == CRDT_MAX) err_crdt_ovf <= 1'b1;
               else                      crdt_cnt     <= crdt_cnt + CNT_ONE;
            end
            default: crdt_cnt <= crdt_cnt;
         endcase
      end
   end

endmodule

// File: doc/swb_isu.md
SWB_ISU -- requirements
Module: swb_isu

Interface
REQ-001 Parameter SWB_DEPTH, default 8: number of store write buffer entries, which is also the initial credit count; power of two.
REQ-002 Parameter IQ_DEPTH, default 4: number of entries in the input queue; power of two, at least 2.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rstn  input  1  reset, synchronous, active-low.
REQ-005 u_req_valid  input  1  upstream store request valid.
REQ-006 u_req_ready  output  1  input queue can accept a request.
REQ-007 u_req_addr  input  32  store address.
REQ-008 u_req_data  input  128  store payload.
REQ-009 d_req_valid  output  1  request is being issued to the downstream SWB path.
REQ-010 d_req_ready  input  1  downstream accepts the issued request.
REQ-011 d_req_id  output  $clog2(SWB_DEPTH)  SWB slot id assigned to the issued request.
REQ-012 d_req_addr  output  32  issued store address.
REQ-013 d_req_data  output  128  issued store payload.
REQ-014 d_isu_crdt_rtn  input  1  one-cycle pulse from the SWB; each pulse returns one credit.
REQ-015 crdt_cnt  output  $clog2(SWB_DEPTH+1)  number of credits currently available.
REQ-016 idle  output  1  high when the queue is empty and crdt_cnt equals SWB_DEPTH.
REQ-017 err_crdt_ovf  output  1  sticky flag: a credit was returned while the counter was already full.

Function
REQ-018 Upstream accept: the request is accepted when u_req_valid and u_req_ready are both high.
REQ-019 u_req_ready shall be high exactly when the queue is not full; no bypass, so a full queue refuses input even if it pops in the same cycle.
REQ-020 Queue: FIFO order; on accept, write {addr, data} at the write pointer.
REQ-021 Queue pointers: each pointer is $clog2(IQ_DEPTH)+1 bits wide and wraps modulo 2*IQ_DEPTH.
REQ-022 Queue full/empty: empty when the pointers are equal; full when the index bits are equal and the MSBs differ.
REQ-023 Issue condition: d_req_valid shall be (queue not empty) AND (crdt_cnt != 0), decoded from registers only.
REQ-024 Issue fields: d_req_addr and d_req_data shall show the queue head.
REQ-025 Issue stability: once d_req_valid is high, it and all d_req_* fields shall hold stable until d_req_ready is sampled high.
REQ-026 Latency: a request accepted into an empty queue, with credit available, shall present d_req_valid in the following cycle.
REQ-027 Issue handshake: d_req_valid and d_req_ready both high pops the queue.
REQ-028 ID counter: on each issue handshake the ID counter shall increment and wrap from SWB_DEPTH-1 to 0; d_req_id shall show its current value.
REQ-029 Credit update, issue only: crdt_cnt decrements by 1.
REQ-030 Credit update, return only: crdt_cnt increments by 1.
REQ-031 Credit update, issue and return in the same cycle: crdt_cnt is unchanged.
REQ-032 Credit at zero: a return arriving when crdt_cnt is 0 makes d_req_valid eligible in the next cycle.
REQ-033 Credit overflow: a return with no issue while crdt_cnt equals SWB_DEPTH shall leave crdt_cnt unchanged and set err_crdt_ovf.
REQ-034 Simultaneous accept and issue on a non-full queue: both shall take effect and the occupancy is unchanged.

Reset
REQ-035 With rstn low at the clock edge: queue pointers = 0, ID counter = 0, crdt_cnt = SWB_DEPTH, err_crdt_ovf = 0.
REQ-036 Resulting output values after reset: u_req_ready = 1, d_req_valid = 0, idle = 1.
REQ-037 Queue payload storage is not reset.
REQ-038 Reset during operation discards all queued requests; credits held by the SWB are not reconciled, so the SWB must be reset in the same cycle.

Structure
REQ-039 Shared package swb_pkg: SWB_DEPTH default, SWB_ID_W, and the typedef swb_req_t {addr[31:0], data[127:0]}; SWB_ID_W and SWB_DEPTH shall be shared with the SWB.
REQ-040 Sub-module: one sync_fifo (parameters: width and depth; ports push, pop, full, empty) implements the queue.
REQ-041 The credit counter and the ID counter shall be implemented in swb_isu itself.

Verification
REQ-042 Reset, then hold d_req_ready=1 and push 8 requests back-to-back with no credit returns -> exactly 8 issues with ids 0..7, crdt_cnt reaches 0, d_req_valid low; a single return pulse -> the 9th request issues with id 0.
REQ-043 Hold d_req_ready=0 and push 4 requests -> u_req_ready drops after the 4th accept; d_req_addr/data stay at request #1 throughout the stall.
REQ-044 With crdt_cnt=3, issue handshake and d_isu_crdt_rtn in the same cycle -> crdt_cnt stays 3.
REQ-045 At idle, pulse d_isu_crdt_rtn -> crdt_cnt stays 8 and err_crdt_ovf=1 until reset.
REQ-046 With the queue full, drive u_req_valid=1 and d_req_ready=1 -> no accept that cycle; accepted the next cycle; FIFO order preserved.
REQ-047 Assert rstn low with 3 requests queued and 2 credits out -> next cycle crdt_cnt=8, queue empty, idle=1, d_req_id=0.
